ctrl_pipe: RTL
==============

# ctrl_pipe

Pipeline control tracker for the 5-stage MIPS core. It takes the decoded control bundle and register numbers from the ID stage and carries them through the ID/EX, EX/MEM and MEM/WB registers. It raises the load-use stall and produces the ID-stage forwarding selects for both source operands. The datapath consumes its per-stage outputs: `ex_*` drives the ALU, `mem_*` drives data memory, and `wb_*` drives the register-file write port.

## Interface
Parameters:
- `RAW` (default 5): register-number width.

Ports:
- `clk`, in, 1: core clock; all state updates on the rising edge.
- `clrn`, in, 1: reset, asynchronous, active-low.
- `id_wreg`, `id_m2reg`, `id_wmem`, `id_aluimm`, `id_regrt`, in, 1 each: decoded control for the instruction in ID.
- `id_aluc`, in, 4: ALU op for the instruction in ID.
- `id_users`, `id_usert`, in, 1 each: the ID instruction reads rs / rt.
- `id_rs`, `id_rt`, `id_rd`, in, `RAW` each: ID register fields.
- `stall`, out, 1: load-use hazard; IF/ID and PC must hold.
- `fwda`, `fwdb`, out, 2: operand select for rs / rt.
  - 00 = register file
  - 01 = EX ALU result
  - 10 = MEM ALU result
  - 11 = MEM load data
- `ex_wreg`, `ex_m2reg`, `ex_wmem`, `ex_aluimm`, out, 1 each: control registered into EX.
- `ex_aluc`, out, 4: ALU op registered into EX.
- `ex_dest`, out, `RAW`: EX destination register.
- `mem_wreg`, `mem_m2reg`, `mem_wmem`, out, 1 each: control registered into MEM.
- `mem_dest`, out, `RAW`: MEM destination register.
- `wb_wreg`, `wb_m2reg`, out, 1 each: control registered into WB.
- `wb_dest`, out, `RAW`: WB destination register.
- `stall_cnt`, `retire_cnt`, out, 32 each: present only with `CTRL_PIPE_STATS_EN`.

## Operation
- **Destination:** `dest = id_regrt ? id_rt : id_rd`. If `dest == 0`, `wreg` is forced to 0 when latched into EX, so r0 is never written and never forwarded.
- **Stall:** asserted when all of the following hold:
  - `ex_wreg & ex_m2reg`
  - `ex_dest != 0`
  - `(id_users & ex_dest == id_rs) | (id_usert & ex_dest == id_rt)`
- **Behaviour during stall:**
  - EX latches a bubble: all `ex_*` control bits are 0, `ex_aluc` = 0, `ex_dest` = 0.
  - MEM and WB advance normally.
- **fwda** (rs; fwdb is identical with rt, gated by `id_usert`). Priority, first match wins:
  1. `ex_wreg & !ex_m2reg & ex_dest == rs & rs != 0` → 01
  2. `mem_wreg & mem_dest == rs & rs != 0` → 10 if `!mem_m2reg`, 11 if `mem_m2reg`
  3. otherwise → 00
- **Forwarding under stall:** when `stall` is asserted, fwda/fwdb are still computed, but the datapath ignores them.
- **Stage transfer (no stall):**
  - ID→EX copies all control bits and dest.
  - EX→MEM copies `wreg`, `m2reg`, `wmem`, `dest`.
  - MEM→WB copies `wreg`, `m2reg`, `dest`.
- **Dropped fields:** `id_wmem` does not propagate past MEM; `aluimm` and `aluc` do not propagate past EX.
- **No-op:** an instruction with all control bits 0 flows through as a no-op.

## Timing
- **Reset:** while `clrn` = 0, every stage register is 0 (the pipe is full of bubbles). Consequently:
  - `stall` = 0 and `fwda` = `fwdb` = 00.
  - Counters are 0.
- **Reset mid-operation:** clears immediately, asynchronously; in-flight writes are lost.
- **Latency:** ID inputs appear on `ex_*` one edge later, `mem_*` two edges, `wb_*` three edges.
- **Combinational outputs:** `stall`, `fwda`, `fwdb` are combinational from ID inputs and the EX/MEM registers, valid in the same cycle. The datapath samples them at the next edge.
- **Load followed by a dependent instruction:**
  - Exactly one stall cycle, then `fwd` = 11 from MEM.
  - Dependency two instructions later: no stall, `fwd` = 11.
  - Dependency three instructions later: `fwd` = 00. The register file writes in the first half-cycle, so no WB forwarding is required.
- **EX and MEM both match:** EX wins.

## Configuration
- `CTRL_PIPE_STATS_EN` defined:
  - `stall_cnt` increments on every edge with `stall` = 1.
  - `retire_cnt` increments on every edge where the MEM stage holds a non-bubble (any of `mem_wreg` / `mem_wmem` set). This counts the instruction entering WB.
  - Both are 32-bit, wrap modulo 2^32, and are cleared by `clrn`.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- **Shared package `mips_pkg`:**
  - `RAW`
  - forwarding-select constants `FWD_RF` = 00, `FWD_EXALU` = 01, `FWD_MEMALU` = 10, `FWD_MEMLD` = 11
  - the ALU op code for add (0010)
- **Sub-module `ctrl_fwd_sel`:** combinational, instantiated twice (rs, rt). Inputs are the register number, its use flag, and the EX/MEM wreg/m2reg/dest; the output is the 2-bit select.
- **Top level:** holds the stage registers and the stall logic.

## Test plan
- **Reset:** `clrn` low mid-stream with `ex_wreg` = 1 → all outputs 0 immediately. After release, the first ID add (rd = 3) appears at `ex_dest` = 3 one edge later and at `wb_dest` = 3 three edges later.
- **Load-use:** lw r2 (`id_regrt` = 1, rt = 2) then add r4, r2, r5.
  - `stall` = 1 for exactly one cycle; EX holds a bubble (`ex_wreg` = 0).
  - Next cycle `fwda` = 11.
  - With stats enabled, `stall_cnt` = 1.
- **Forwarding priority:** add r1; add r1; add r6, r1, r1 → `fwda` = `fwdb` = 01 (EX beats MEM). Inserting a no-op between the last two gives 10.
- **r0:** add with rd = 0, then a reader of r0 → `ex_wreg` = 0, `fwda` = 00, no stall, `wb_wreg` = 0.
- **No false stall:** lw r7, then an instruction with `id_users` = 0 and `id_usert` = 0 whose rs = 7 → `stall` = 0.
- **Counters (stats enabled):** 10 back-to-back adds with no hazards → `retire_cnt` = 10 after 13 edges, `stall_cnt` = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg: definitions shared by the 5-stage MIPS core control path.
//   RAW        : default register-number width
//   fwd_sel_e  : ID-stage operand forwarding selects
//   ALU_ADD    : ALU op code for add
// ---------------------------------------------------------------------------
package mips_pkg;

   localparam int RAW = 5;

   typedef enum logic [1:0] {
      FWD_RF     = 2'b00,  // register file
      FWD_EXALU  = 2'b01,  // ALU result of the instruction in EX
      FWD_MEMALU = 2'b10,  // ALU result of the instruction in MEM
      FWD_MEMLD  = 2'b11   // load data of the instruction in MEM
   } fwd_sel_e;

   localparam logic [3:0] ALU_ADD = 4'b0010;

endpackage

// File: rtl/ctrl_fwd_sel.sv
// ---------------------------------------------------------------------------
// ctrl_fwd_sel: forwarding select for one ID-stage source operand.
//   rn, use_rn                   : source register number and its use flag
//   ex_wreg, ex_m2reg, ex_dest   : control held in the ID/EX register
//   mem_wreg, mem_m2reg, mem_dest: control held in the EX/MEM register
//   sel                          : 2-bit operand select (fwd_sel_e encoding)
// Purely combinational.
// ---------------------------------------------------------------------------
module ctrl_fwd_sel
#(
   parameter int RAW = 5
)
(
   input  logic [RAW-1:0] rn,
   input  logic           use_rn,
   input  logic           ex_wreg,
   input  logic           ex_m2reg,
   input  logic [RAW-1:0] ex_dest,
   input  logic           mem_wreg,
   input  logic           mem_m2reg,
   input  logic [RAW-1:0] mem_dest,
   output logic [1:0]     sel
);
   import mips_pkg::*;

   always_comb begin
      // NOTE: default first, so every path assigns sel and no latch is inferred.
      sel = FWD_RF;
      if (use_rn && (rn != '0)) begin
         // A load in EX has no data yet; that case is the stall, not a forward.
         if (ex_wreg && !ex_m2reg && (ex_dest == rn)) begin
            sel = FWD_EXALU;
         end else if (mem_wreg && (mem_dest == rn)) begin
            sel = mem_m2reg ? FWD_MEMLD : FWD_MEMALU;
         end
      end
   end

endmodule

// File: rtl/ctrl_pipe.sv
// ---------------------------------------------------------------------------
// ctrl_pipe: control tracker for the 5-stage MIPS pipeline.
// Carries the decoded ID control bundle through ID/EX, EX/MEM and MEM/WB,
// raises the load-use stall and produces forwarding selects for rs and rt.
//   clk, clrn           : core clock, asynchronous active-low reset
//   id_*                : decoded control and register fields from ID
//   stall               : load-use hazard, IF/ID and PC hold
//   fwda, fwdb          : operand selects for rs / rt (fwd_sel_e encoding)
//   ex_*, mem_*, wb_*   : control registered into each stage
//   stall_cnt,
//   retire_cnt          : statistics, present only with CTRL_PIPE_STATS_EN
// Optional feature macro: CTRL_PIPE_STATS_EN
// ---------------------------------------------------------------------------
module ctrl_pipe
#(
   parameter int RAW = mips_pkg::RAW
)
(
   input  logic           clk,
   input  logic           clrn,
   input  logic           id_wreg,
   input  logic           id_m2reg,
   input  logic           id_wmem,
   input  logic           id_aluimm,
   input  logic           id_regrt,
   input  logic [3:0]     id_aluc,
   input  logic           id_users,
   input  logic           id_usert,
   input  logic [RAW-1:0] id_rs,
   input  logic [RAW-1:0] id_rt,
   input  logic [RAW-1:0] id_rd,
   output logic           stall,
   output logic [1:0]     fwda,
   output logic [1:0]     fwdb,
   output logic           ex_wreg,
   output logic           ex_m2reg,
   output logic           ex_wmem,
   output logic           ex_aluimm,
   output logic [3:0]     ex_aluc,
   output logic [RAW-1:0] ex_dest,
   output logic           mem_wreg,
   output logic           mem_m2reg,
   output logic           mem_wmem,
   output logic [RAW-1:0] mem_dest,
   output logic           wb_wreg,
   output logic           wb_m2reg,
`ifdef CTRL_PIPE_STATS_EN
   output logic [RAW-1:0] wb_dest,
   output logic [31:0]    stall_cnt,
   output logic [31:0]    retire_cnt
`else
   output logic [RAW-1:0] wb_dest
`endif
);
   import mips_pkg::*;

   logic           ex_wreg_q,   ex_wreg_d;
   logic           ex_m2reg_q,  ex_m2reg_d;
   logic           ex_wmem_q,   ex_wmem_d;
   logic           ex_aluimm_q, ex_aluimm_d;
   logic [3:0]     ex_aluc_q,   ex_aluc_d;
   logic [RAW-1:0] ex_dest_q,   ex_dest_d;
   logic           mem_wreg_q,  mem_wreg_d;
   logic           mem_m2reg_q, mem_m2reg_d;
   logic           mem_wmem_q,  mem_wmem_d;
   logic [RAW-1:0] mem_dest_q,  mem_dest_d;
   logic           wb_wreg_q,   wb_wreg_d;
   logic           wb_m2reg_q,  wb_m2reg_d;
   logic [RAW-1:0] wb_dest_q,   wb_dest_d;

   logic [RAW-1:0] id_dest;
   logic           load_in_ex;

   assign id_dest = id_regrt ? id_rt : id_rd;

   // Load-use: the loaded value is not available until the end of MEM.
   always_comb begin
      load_in_ex = ex_wreg_q & ex_m2reg_q & (ex_dest_q != '0);
      stall      = load_in_ex &
                   ((id_users & (ex_dest_q == id_rs)) |
                    (id_usert & (ex_dest_q == id_rt)));
   end

   ctrl_fwd_sel #(.RAW(RAW)) u_fwd_rs (
      .rn        (id_rs),
      .use_rn    (id_users),
      .ex_wreg   (ex_wreg_q),
      .ex_m2reg  (ex_m2reg_q),
      .ex_dest   (ex_dest_q),
      .mem_wreg  (mem_wreg_q),
      .mem_m2reg (mem_m2reg_q),
      .mem_dest  (mem_dest_q),
      .sel       (fwda)
   );

   ctrl_fwd_sel #(.RAW(RAW)) u_fwd_rt (
      .rn        (id_rt),
      .use_rn    (id_usert),
      .ex_wreg   (ex_wreg_q),
      .ex_m2reg  (ex_m2reg_q),
      .ex_dest   (ex_dest_q),
      .mem_wreg  (mem_wreg_q),
      .mem_m2reg (mem_m2reg_q),
      .mem_dest  (mem_dest_q),
      .sel       (fwdb)
   );

   always_comb begin
      // ID -> EX; a stall injects a bubble, and a write to r0 is dropped here
      // so it can neither update the register file nor be forwarded.
      ex_wreg_d   = 1'b0;
      ex_m2reg_d  = 1'b0;
      ex_wmem_d   = 1'b0;
      ex_aluimm_d = 1'b0;
      ex_aluc_d   = 4'b0000;
      ex_dest_d   = '0;
      if (!stall) begin
         ex_wreg_d   = id_wreg & (id_dest != '0);
         ex_m2reg_d  = id_m2reg;
         ex_wmem_d   = id_wmem;
         ex_aluimm_d = id_aluimm;
         ex_aluc_d   = id_aluc;
         ex_dest_d   = id_dest;
      end

      // EX -> MEM and MEM -> WB always advance.
      mem_wreg_d  = ex_wreg_q;
      mem_m2reg_d = ex_m2reg_q;
      mem_wmem_d  = ex_wmem_q;
      mem_dest_d  = ex_dest_q;
      wb_wreg_d   = mem_wreg_q;
      wb_m2reg_d  = mem_m2reg_q;
      wb_dest_d   = mem_dest_q;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         // NOTE: non-blocking assignments so every stage samples the
         // pre-edge value of the stage before it.
         ex_wreg_q   <= 1'b0;
         ex_m2reg_q  <= 1'b0;
         ex_wmem_q   <= 1'b0;
         ex_aluimm_q <= 1'b0;
         ex_aluc_q   <= 4'b0000;
         ex_dest_q   <= '0;
         mem_wreg_q  <= 1'b0;
         mem_m2reg_q <= 1'b0;
         mem_wmem_q  <= 1'b0;
         mem_dest_q  <= '0;
         wb_wreg_q   <= 1'b0;
         wb_m2reg_q  <= 1'b0;
         wb_dest_q   <= '0;
      end else begin
         ex_wreg_q   <= ex_wreg_d;
         ex_m2reg_q  <= ex_m2reg_d;
         ex_wmem_q   <= ex_wmem_d;
         ex_aluimm_q <= ex_aluimm_d;
         ex_aluc_q   <= ex_aluc_d;
         ex_dest_q   <= ex_dest_d;
         mem_wreg_q  <= mem_wreg_d;
         mem_m2reg_q <= mem_m2reg_d;
         mem_wmem_q  <= mem_wmem_d;
         mem_dest_q  <= mem_dest_d;
         wb_wreg_q   <= wb_wreg_d;
         wb_m2reg_q  <= wb_m2reg_d;
         wb_dest_q   <= wb_dest_d;
      end
   end

   assign ex_wreg   = ex_wreg_q;
   assign ex_m2reg  = ex_m2reg_q;
   assign ex_wmem   = ex_wmem_q;
   assign ex_aluimm = ex_aluimm_q;
   assign ex_aluc   = ex_aluc_q;
   assign ex_dest   = ex_dest_q;
   assign mem_wreg  = mem_wreg_q;
   assign mem_m2reg = mem_m2reg_q;
   assign mem_wmem  = mem_wmem_q;
   assign mem_dest  = mem_dest_q;
   assign wb_wreg   = wb_wreg_q;
   assign wb_m2reg  = wb_m2reg_q;
   assign wb_dest   = wb_dest_q;

`ifdef CTRL_PIPE_STATS_EN
   logic [31:0] stall_cnt_q,  stall_cnt_d;
   logic [31:0] retire_cnt_q, retire_cnt_d;

   // A non-bubble in MEM is the instruction about to enter WB.
   always_comb begin
      stall_cnt_d  = stall_cnt_q  + {31'd0, stall};
      retire_cnt_d = retire_cnt_q + {31'd0, mem_wreg_q | mem_wmem_q};
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         stall_cnt_q  <= 32'd0;
         retire_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign retire_cnt = retire_cnt_q;
`endif

endmodule
